branch_predictor: RTL

//  Fetch-stage conditional-branch predictor for the pipelined Y86-64 core: a table of 2-bit saturating counters.

---
 rtl/branch_predictor_pkg.sv | 16 +
 rtl/branch_predictor_if.sv | 36 +++
 rtl/bp_sat_counter.sv | 20 ++
 rtl/branch_predictor.sv | 98 +++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-stage branch predictor: Y86-64 icodes
// and the 2-bit saturating counter encodings.
package branch_predictor_pkg;

   localparam logic [3:0] INOP  = 4'h1;
   localparam logic [3:0] IJXX  = 4'h7;
   localparam logic [3:0] ICALL = 4'h8;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_cnt_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the branch
// predictor. The pipeline drives through "master", the predictor is "slave".
interface branch_predictor_if #(
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned STAT_W = 32
);
   logic [63:0]       f_pc_i;
   logic [3:0]        f_icode_i;
   logic [3:0]        f_ifun_i;
   logic [63:0]       f_valC_i;
   logic [63:0]       f_valP_i;
   logic              f_pred_taken_o;
   logic [63:0]       f_predPC_o;
   logic [IDX_W-1:0]  f_bp_idx_o;
   logic [3:0]        E_icode_i;
   logic [3:0]        E_ifun_i;
   logic [IDX_W-1:0]  E_bp_idx_i;
   logic              E_branch_taken_i;
   logic              e_Cnd_i;
   logic [STAT_W-1:0] br_cnt_o;
   logic [STAT_W-1:0] mispred_cnt_o;

   modport master (
      output f_pc_i, f_icode_i, f_ifun_i, f_valC_i, f_valP_i,
      output E_icode_i, E_ifun_i, E_bp_idx_i, E_branch_taken_i, e_Cnd_i,
      input  f_pred_taken_o, f_predPC_o, f_bp_idx_o,
      input  br_cnt_o, mispred_cnt_o
   );

   modport slave (
      input  f_pc_i, f_icode_i, f_ifun_i, f_valC_i, f_valP_i,
      input  E_icode_i, E_ifun_i, E_bp_idx_i, E_branch_taken_i, e_Cnd_i,
      output f_pred_taken_o, f_predPC_o, f_bp_idx_o,
      output br_cnt_o, mispred_cnt_o
   );
endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state logic used on the training path.
module bp_sat_counter
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       taken,
   output logic [1:0] cnt_next
);

   // Step toward ST on taken, toward SNT on not-taken, holding at the ends.
   always_comb begin
      cnt_next = cnt;
      if (taken) begin
         if (cnt != ST) cnt_next = cnt + 2'd1;
      end else begin
         if (cnt != SNT) cnt_next = cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage conditional-branch predictor: table of 2-bit saturating
// counters, trained when the branch resolves in E, plus saturating
// branch/mispredict statistics.
// Optional feature: define BP_GSHARE_EN to XOR a non-speculative global
// history register into the lookup index (gshare); otherwise bimodal.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int unsigned IDX_W    = 6,
   parameter logic [1:0]  CNT_INIT = WNT,
   parameter int unsigned STAT_W   = 32
) (
   input logic               clk_i,
   input logic               rst_i,
   branch_predictor_if.slave bp
);

   localparam int unsigned DEPTH = 2**IDX_W;

   // Flat register array so the whole table clears on async reset.
   logic [1:0]       cnt_tbl [DEPTH];
   logic [IDX_W-1:0] f_idx;
   logic             f_pred;
   logic             upd;
   logic             mispred;
   logic [1:0]       cnt_cur;
   logic [1:0]       cnt_upd;
   logic [STAT_W-1:0] br_cnt;
   logic [STAT_W-1:0] mispred_cnt;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      if (&v) return v;
      return v + {{(STAT_W-1){1'b0}}, 1'b1};
   endfunction

`ifdef BP_GSHARE_EN
   logic [IDX_W-1:0] ghr;
   assign f_idx = bp.f_pc_i[IDX_W-1:0] ^ ghr;
`else
   assign f_idx = bp.f_pc_i[IDX_W-1:0];
`endif

   // Lookup: jmp always taken, conditional jumps follow the counter MSB.
   always_comb begin
      f_pred = 1'b0;
      if (bp.f_icode_i == IJXX) begin
         if (bp.f_ifun_i == 4'h0) f_pred = 1'b1;
         else                     f_pred = cnt_tbl[f_idx][1];
      end
   end

   assign bp.f_pred_taken_o = f_pred;
   assign bp.f_predPC_o     = ((bp.f_icode_i == ICALL) || f_pred) ? bp.f_valC_i : bp.f_valP_i;
   assign bp.f_bp_idx_o     = f_idx;

   // Only conditional jumps train; jmp, call, ret and bubbles are ignored.
   assign upd     = (bp.E_icode_i == IJXX) && (bp.E_ifun_i != 4'h0);
   assign mispred = bp.e_Cnd_i != bp.E_branch_taken_i;
   assign cnt_cur = cnt_tbl[bp.E_bp_idx_i];

   bp_sat_counter u_sat (
      .cnt      (cnt_cur),
      .taken    (bp.e_Cnd_i),
      .cnt_next (cnt_upd)
   );

   // Table training; lookups in the same cycle see the pre-update value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) cnt_tbl[i] <= CNT_INIT;
      end else if (upd) begin
         cnt_tbl[bp.E_bp_idx_i] <= cnt_upd;
      end
   end

   // Statistics counters, saturating at all-ones.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         br_cnt      <= '0;
         mispred_cnt <= '0;
      end else if (upd) begin
         br_cnt <= sat_inc(br_cnt);
         if (mispred) mispred_cnt <= sat_inc(mispred_cnt);
      end
   end

`ifdef BP_GSHARE_EN
   // Global history shifts in resolved outcomes only (non-speculative).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)    ghr <= '0;
      else if (upd) ghr <= {ghr[IDX_W-2:0], bp.e_Cnd_i};
   end
`endif

   assign bp.br_cnt_o      = br_cnt;
   assign bp.mispred_cnt_o = mispred_cnt;

endmodule
